// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame length,
// timing defaults and frame/parity helpers used by host TX (and RX).
package ps2_pkg;

    // Host transmitter states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INHIBIT  = 3'd1,
        RTS      = 3'd2,
        SHIFT    = 3'd3,
        ACK      = 3'd4,
        WAIT_REL = 3'd5
    } ps2_tx_state_e;

    // Default system clock and the divisors that turn it into the
    // 100 us inhibit window and the 15 ms whole-frame timeout
    localparam int DEF_CLK_FREQ = 24000000;
    localparam int INHIBIT_DIV  = 10000;
    localparam int TIMEOUT_MUL  = 15;
    localparam int TIMEOUT_DIV  = 1000;

    // Start + 8 data + parity + stop; the 11th device clock carries the ACK
    localparam logic [3:0] FRAME_LEN = 4'd11;
    localparam int         FRAME_W   = 11;

    // Odd parity: 1 when the byte holds an even number of ones
    function automatic logic odd_parity(input logic [7:0] data);
        return ~(^data);
    endfunction

    // Frame bit 0 is the start bit, bits 1..8 data LSB first, 9 parity, 10 stop
    function automatic logic [FRAME_W-1:0] build_frame(input logic [7:0] data);
        return {1'b1, odd_parity(data), data, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchroniser for a raw PS/2 line with falling-edge detection.
// Flops reset to 1 (idle bus level) so reset never fakes a falling edge.
module ps2_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronise the asynchronous line and keep one cycle of history
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues request-to-send,
// shifts a byte out on device clock falling edges, checks the ACK and waits
// for the bus to be released. A whole-frame timeout recovers a dead device.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ    = DEF_CLK_FREQ,
    parameter int INHIBIT_CYC = CLK_FREQ / INHIBIT_DIV,
    parameter int TIMEOUT_CYC = CLK_FREQ * TIMEOUT_MUL / TIMEOUT_DIV
) (
    input  logic       clk_bus,
    input  logic       bus_reset,
    input  logic [7:0] tx_data,
    input  logic       tx_stb,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int INH_W = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = {TO_W{1'b1}};

    ps2_tx_state_e      state_q,    state_d;
    logic [FRAME_W-1:0] frame_q,    frame_d;
    logic [INH_W-1:0]   inh_cnt_q,  inh_cnt_d;
    logic [3:0]         edge_cnt_q, edge_cnt_d;
    logic [TO_W-1:0]    to_cnt_q,   to_cnt_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic               err_q,      err_d;
    logic               clk_oe_q,   clk_oe_d;
    logic               dat_oe_q,   dat_oe_d;

    logic clk_lvl_s;
    logic clk_fall_s;
    logic dat_lvl_s;
    logic dat_fall_s;
    logic in_frame_s;
    logic timeout_s;

    ps2_sync u_sync_clk (
        .clk_i   (clk_bus),
        .rst_i   (bus_reset),
        .line_i  (PS2_CLK),
        .level_o (clk_lvl_s),
        .fall_o  (clk_fall_s)
    );

    ps2_sync u_sync_dat (
        .clk_i   (clk_bus),
        .rst_i   (bus_reset),
        .line_i  (PS2_DAT),
        .level_o (dat_lvl_s),
        .fall_o  (dat_fall_s)
    );

    // Data falling edges are not needed by the transmitter itself
    logic unused_s;
    assign unused_s = dat_fall_s;

    // The timeout runs from RTS entry until the frame returns to IDLE
    assign in_frame_s = (state_q == RTS) || (state_q == SHIFT) ||
                        (state_q == ACK) || (state_q == WAIT_REL);
    assign timeout_s  = in_frame_s && (to_cnt_q >= TO_LAST);

    // Next-state, counters and line/strobe outputs of the transmit FSM
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        inh_cnt_d  = inh_cnt_q;
        edge_cnt_d = edge_cnt_q;
        to_cnt_d   = to_cnt_q;
        clk_oe_d   = clk_oe_q;
        dat_oe_d   = dat_oe_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        // Saturating frame timer
        if (in_frame_s && (to_cnt_q != TO_MAX)) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end else begin
            to_cnt_d = to_cnt_q;
        end

        case (state_q)
            IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                to_cnt_d = '0;
                if (tx_stb) begin
                    frame_d    = build_frame(tx_data);
                    inh_cnt_d  = '0;
                    edge_cnt_d = 4'd0;
                    clk_oe_d   = 1'b1;
                    state_d    = INHIBIT;
                end else begin
                    state_d = IDLE;
                end
            end
            INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    // Release clock and pull data low for the start bit
                    clk_oe_d = 1'b0;
                    dat_oe_d = ~frame_q[0];
                    to_cnt_d = '0;
                    state_d  = RTS;
                end else begin
                    inh_cnt_d = inh_cnt_q + INH_W'(1);
                end
            end
            RTS, SHIFT: begin
                if (clk_fall_s) begin
                    edge_cnt_d = edge_cnt_q + 4'd1;
                    frame_d    = {1'b1, frame_q[FRAME_W-1:1]};
                    if ((edge_cnt_q + 4'd1) == FRAME_LEN) begin
                        dat_oe_d = 1'b0;
                        state_d  = ACK;
                    end else begin
                        // Edges 1..10 put out data, parity, then stop (release)
                        dat_oe_d = ~frame_q[1];
                        state_d  = SHIFT;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ACK: begin
                dat_oe_d = 1'b0;
                if (!dat_lvl_s) begin
                    state_d = WAIT_REL;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_REL: begin
                if (clk_lvl_s && dat_lvl_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_REL;
                end
            end
            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = IDLE;
            end
        endcase

        // Timeout wins over any completion decided in the same cycle
        if (timeout_s) begin
            done_d   = 1'b0;
            err_d    = 1'b1;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            state_d  = IDLE;
        end else begin
            state_d = state_d;
        end

        busy_d = (state_d != IDLE);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk_bus) begin
        if (bus_reset) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            inh_cnt_q  <= '0;
            edge_cnt_q <= 4'd0;
            to_cnt_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            inh_cnt_q  <= inh_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            to_cnt_q   <= to_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
        end
    end

    assign tx_busy    = busy_q;
    assign tx_done    = done_q;
    assign tx_err     = err_q;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-collector bus with a behavioural device
// that clocks frames in, and a frame-level reference model.
module tb_ps2_host_tx;

    localparam int CLK_FREQ = 500000;
    localparam int INH      = 50;
    localparam int TO       = 1000;
    localparam int HALF     = 20;

    logic       clk_bus   = 1'b0;
    logic       bus_reset = 1'b1;
    logic [7:0] tx_data   = 8'h00;
    logic       tx_stb    = 1'b0;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       PS2_CLK;
    logic       PS2_DAT;

    assign PS2_CLK = ~ps2_clk_oe & ~dev_clk_low;
    assign PS2_DAT = ~ps2_dat_oe & ~dev_dat_low;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int cyc      = 0;
    int inh_run  = 0;
    int last_inh = 0;

    logic [9:0] bits;
    logic       sb;

    ps2_host_tx #(
        .CLK_FREQ    (CLK_FREQ),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_bus    (clk_bus),
        .bus_reset  (bus_reset),
        .tx_data    (tx_data),
        .tx_stb     (tx_stb),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .PS2_CLK    (PS2_CLK),
        .PS2_DAT    (PS2_DAT),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    always #5 clk_bus = ~clk_bus;

    always @(posedge clk_bus) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse monitor and inhibit-length measurement
    always @(negedge clk_bus) begin
        if (tx_done) done_cnt++;
        if (tx_err)  err_cnt++;
        if (tx_done || tx_err) begin
            check_eq("done_err_excl", 32'(tx_done & tx_err), 32'd0);
            check_eq("busy_at_pulse", 32'(tx_busy), 32'd0);
        end
        if (ps2_clk_oe) begin
            inh_run++;
        end else if (inh_run != 0) begin
            last_inh = inh_run;
            inh_run  = 0;
        end
    end

    // Frame as the device should see it: data LSB first, odd parity, stop
    function automatic logic [9:0] ref_frame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d};
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_bus);
    endtask

    task automatic send_byte(input logic [7:0] d);
        @(negedge clk_bus);
        tx_data = d;
        tx_stb  = 1'b1;
        @(negedge clk_bus);
        tx_stb  = 1'b0;
        check_eq("busy_rise", 32'(tx_busy), 32'd1);
    endtask

    // Device: waits for request-to-send, then clocks 11 pulses, sampling
    // on rising edges; optionally ACKs, optionally stops after an edge.
    task automatic device_frame(input bit do_ack, input int abort_edge,
                                output logic [9:0] got, output logic start_bit);
        int budget = 0;
        got       = '1;
        start_bit = 1'b1;
        while (!(ps2_dat_oe && !ps2_clk_oe) && budget < 2000) begin
            @(negedge clk_bus);
            budget++;
        end
        if (budget >= 2000) begin
            check_eq("rts_seen", 32'd0, 32'd1);
            return;
        end
        wait_cycles(10);
        start_bit = PS2_DAT;
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && do_ack) begin
                dev_dat_low = 1'b1;
                wait_cycles(5);
            end
            dev_clk_low = 1'b1;
            wait_cycles(HALF);
            if (k == abort_edge) return;
            dev_clk_low = 1'b0;
            if (k <= 10) got[k-1] = PS2_DAT;
            if (k == 11) dev_dat_low = 1'b0;
            wait_cycles(HALF);
        end
    endtask

    task automatic do_frame(input logic [7:0] d, input bit do_ack, output logic [9:0] got);
        int d0 = done_cnt;
        int e0 = err_cnt;
        logic st;
        send_byte(d);
        device_frame(do_ack, 0, got, st);
        wait_cycles(10);
        check_eq("start_bit", 32'(st), 32'd0);
        check_eq("inhibit_len", 32'(last_inh), 32'(INH));
        if (do_ack) begin
            check_eq("frame_bits", 32'(got), 32'(ref_frame(d)));
            check_eq("done_pulses", 32'(done_cnt - d0), 32'd1);
            check_eq("err_pulses", 32'(err_cnt - e0), 32'd0);
        end else begin
            check_eq("nack_err", 32'(err_cnt - e0), 32'd1);
            check_eq("nack_done", 32'(done_cnt - d0), 32'd0);
        end
        check_eq("busy_end", 32'(tx_busy), 32'd0);
        check_eq("lines_released", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
    endtask

    initial begin
        int d0;
        int e0;
        int t0;
        int budget;

        // Reset state
        wait_cycles(3);
        check_eq("rst_busy", 32'(tx_busy), 32'd0);
        check_eq("rst_done", 32'(tx_done), 32'd0);
        check_eq("rst_err", 32'(tx_err), 32'd0);
        check_eq("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check_eq("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        bus_reset = 1'b0;
        wait_cycles(5);

        // Reference byte with literal expectation
        do_frame(8'hED, 1'b1, bits);
        check_eq("ed_literal", 32'(bits), 32'h3ED);

        // Parity boundaries
        do_frame(8'h07, 1'b1, bits);
        check_eq("parity_07", 32'(bits[8]), 32'd0);
        do_frame(8'h00, 1'b1, bits);
        check_eq("parity_00", 32'(bits[8]), 32'd1);

        // Random bytes
        for (int i = 0; i < 4; i++) begin
            do_frame(8'($urandom_range(0, 255)), 1'b1, bits);
        end

        // Device leaves data high at ACK
        do_frame(8'h96, 1'b0, bits);

        // Device never clocks: timeout from RTS entry
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'h3C);
        budget = 0;
        while (!ps2_dat_oe && budget < 500) begin
            @(negedge clk_bus);
            budget++;
        end
        t0 = cyc;
        budget = 0;
        while (!tx_err && budget < 2000) begin
            @(negedge clk_bus);
            budget++;
        end
        check_eq("timeout_cycles", 32'(cyc - t0), 32'(TO));
        check_eq("timeout_lines", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
        wait_cycles(5);
        check_eq("timeout_err", 32'(err_cnt - e0), 32'd1);
        check_eq("timeout_done", 32'(done_cnt - d0), 32'd0);

        // Strobe during a frame is ignored; next strobe after done works
        d0 = done_cnt;
        send_byte(8'h5A);
        fork
            device_frame(1'b1, 0, bits, sb);
            begin
                wait_cycles(150);
                tx_data = 8'hFF;
                tx_stb  = 1'b1;
                wait_cycles(200);
                tx_stb  = 1'b0;
                tx_data = 8'h5A;
            end
        join
        wait_cycles(10);
        check_eq("held_stb_frame", 32'(bits), 32'(ref_frame(8'h5A)));
        check_eq("held_stb_done", 32'(done_cnt - d0), 32'd1);
        check_eq("held_stb_idle", 32'(tx_busy), 32'd0);
        do_frame(8'hC3, 1'b1, bits);

        // Reset after falling edge 5 (bit 4 of 0xA5 is 0, data held low)
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'hA5);
        device_frame(1'b1, 5, bits, sb);
        check_eq("pre_rst_dat_oe", 32'(ps2_dat_oe), 32'd1);
        bus_reset = 1'b1;
        @(negedge clk_bus);
        check_eq("rst_mid_lines", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
        check_eq("rst_mid_busy", 32'(tx_busy), 32'd0);
        bus_reset   = 1'b0;
        dev_clk_low = 1'b0;
        wait_cycles(50);
        check_eq("rst_mid_done", 32'(done_cnt - d0), 32'd0);
        check_eq("rst_mid_err", 32'(err_cnt - e0), 32'd0);
        do_frame(8'h3C, 1'b1, bits);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 24000000, system clock frequency in Hz.
REQ-002 SHALL have parameter INHIBIT_CYC, default CLK_FREQ/10000, clock-low inhibit length (100 us).
REQ-003 SHALL have parameter TIMEOUT_CYC, default CLK_FREQ*15/1000, whole-frame timeout (15 ms).
REQ-004 SHALL have port clk_bus  in  1  single system clock; every flop is clocked on its rising edge.
REQ-005 SHALL have port bus_reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port tx_data  in  8  command byte to send to the device.
REQ-007 SHALL have port tx_stb  in  1  one-cycle send request.
REQ-008 SHALL have port tx_busy  out  1  high while a frame is in progress.
REQ-009 SHALL have port tx_done  out  1  one-cycle pulse when a frame completes and the device acknowledges it.
REQ-010 SHALL have port tx_err  out  1  one-cycle pulse on a missing ACK or on timeout.
REQ-011 SHALL have port PS2_CLK  in  1  raw PS/2 clock line level.
REQ-012 SHALL have port PS2_DAT  in  1  raw PS/2 data line level.
REQ-013 SHALL have port ps2_clk_oe  out  1  1 = pull the clock line low (open collector).
REQ-014 SHALL have port ps2_dat_oe  out  1  1 = pull the data line low (open collector).

Function
REQ-015 SHALL synchronise PS2_CLK and PS2_DAT through 2 flops, then detect a clock falling edge as sync_prev=1, sync_cur=0.
REQ-016 SHALL implement states IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_REL.
REQ-017 SHALL, in IDLE, latch tx_data on tx_stb and enter INHIBIT; tx_busy goes high on the next cycle.
REQ-018 SHALL ignore tx_stb whenever it arrives outside IDLE (no queueing, no error).
REQ-019 SHALL, in INHIBIT, assert ps2_clk_oe for exactly INHIBIT_CYC cycles, then assert ps2_dat_oe (start bit 0) and release the clock, entering RTS.
REQ-020 SHALL build the frame as 8 data bits LSB first, then an odd parity bit (1 when tx_data has an even count of ones), then a stop bit 1.
REQ-021 SHALL, in RTS/SHIFT, advance on device clock falling edges: falling edges 1-8 drive data bits 0-7, edge 9 drives parity, edge 10 releases data (stop), and edge 11 enters ACK.
REQ-022 SHALL drive each bit as ps2_dat_oe = ~bit.
REQ-023 SHALL, in ACK, sample synchronised data on the 11th falling edge: 0 enters WAIT_REL; 1 pulses tx_err and enters IDLE.
REQ-024 SHALL, in WAIT_REL, wait until synchronised clock and data are both 1, then pulse tx_done and enter IDLE.
REQ-025 SHALL start a timeout counter on entry to RTS; if it reaches TIMEOUT_CYC before IDLE, pulse tx_err, release both lines and enter IDLE.
REQ-026 SHALL never pulse tx_done and tx_err in the same cycle; timeout takes priority over an ACK sampled in the same cycle.
REQ-027 SHALL deassert tx_busy in the same cycle that tx_done or tx_err pulses.
REQ-028 SHALL use a 4-bit falling-edge counter, and the timeout counter SHALL saturate and not wrap.

Reset
REQ-029 SHALL, on bus_reset, set state IDLE; tx_busy, tx_done, tx_err, ps2_clk_oe and ps2_dat_oe to 0; and clear all counters.
REQ-030 SHALL, on bus_reset mid-frame, release both lines on the next clk_bus edge and pulse neither tx_done nor tx_err.

Structure
REQ-031 SHALL take the state encoding, the frame length constant (11) and the inhibit/timeout defaults from shared package ps2_pkg.
REQ-032 SHALL instantiate one sub-module, ps2_sync (2-flop synchroniser plus falling-edge detect), reusable by the receiver.

Verification
REQ-033 SHALL verify: tx_data=0xED, device model clocks at 12.5 kHz and ACKs -> bits 1,0,1,1,0,1,1,1, parity 1, stop 1, then one tx_done pulse.
REQ-034 SHALL verify: tx_data=0x07 -> parity bit 0; tx_data=0x00 -> parity bit 1.
REQ-035 SHALL verify: device leaves data high at ACK -> one tx_err pulse, no tx_done, and state returns to IDLE.
REQ-036 SHALL verify: device never clocks, with TIMEOUT_CYC=1000 -> tx_err exactly 1000 cycles after RTS entry, and both oe outputs at 0.
REQ-037 SHALL verify: tx_stb held during a frame -> ignored; a second tx_stb after tx_done sends a new frame correctly.
REQ-038 SHALL verify: bus_reset asserted after falling edge 5 -> oe outputs 0 next cycle, no done/err pulse, and the next send is correct.
